// File: rtl/counter_mod_n.sv
// -----------------------------------------------------------------------------
// counter_mod_n
//
// Purpose:
//   Parametrised synchronous up/down counter with parallel load and a
//   runtime-programmable modulus (count range 0..limit). It provides a
//   combinational ripple-carry output for cascading stages, a registered
//   one-cycle error pulse when a load value has to be clamped, and a
//   saturating counter of wrap events.
//
// Parameters:
//   WIDTH   - bit width of the count, the load data and the limit
//   WRAP_W  - bit width of the wrap-event counter (saturates at all-ones)
//
// Ports:
//   clk       in   1       system clock, rising-edge active
//   rst       in   1       asynchronous reset, active-high
//   enb       in   1       count/load enable; when 0, all state holds
//   modo      in   2       00 up, 01 down, 10 parallel load, 11 hold
//   data      in   WIDTH   parallel load value
//   limit     in   WIDTH   terminal value, sampled on every edge
//   Q         out  WIDTH   current count (registered)
//   rco       out  1       ripple carry: enabled and at terminal for direction
//   load_err  out  1       one-cycle pulse after a clamped load
//   wrap_cnt  out  WRAP_W  wraps since reset, saturating
// -----------------------------------------------------------------------------
module counter_mod_n #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enb,
  input  logic [1:0]        modo,
  input  logic [WIDTH-1:0]  data,
  input  logic [WIDTH-1:0]  limit,
  output logic [WIDTH-1:0]  Q,
  output logic              rco,
  output logic              load_err,
  output logic [WRAP_W-1:0] wrap_cnt
);

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_LOAD = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0]  CNT_ONE  = WIDTH'(1);
  localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);

  mode_e             mode;
  logic [WIDTH-1:0]  count_q;
  logic [WIDTH-1:0]  count_d;
  logic              load_err_q;
  logic              load_err_d;
  logic [WRAP_W-1:0] wrap_q;
  logic [WRAP_W-1:0] wrap_d;
  logic              wrap_evt;
  logic              at_top;
  logic              at_bottom;

  assign mode = mode_e'(modo);

  // ">=" rather than "==" so a count left above a freshly lowered limit
  // still terminates on the next up edge instead of running to 2^WIDTH-1.
  assign at_top    = (count_q >= limit);
  assign at_bottom = (count_q == '0);

  // Next-state logic. load_err defaults low so the pulse clears on any edge
  // that is not itself a clamped load.
  always_comb begin
    count_d    = count_q;
    load_err_d = 1'b0;
    wrap_evt   = 1'b0;
    if (enb) begin
      unique case (mode)
        MODE_UP: begin
          if (at_top) begin
            count_d  = '0;
            wrap_evt = 1'b1;
          end else begin
            count_d = count_q + CNT_ONE;
          end
        end
        MODE_DOWN: begin
          // Decrement even above limit; only reaching zero reloads limit.
          if (at_bottom) begin
            count_d  = limit;
            wrap_evt = 1'b1;
          end else begin
            count_d = count_q - CNT_ONE;
          end
        end
        MODE_LOAD: begin
          if (data > limit) begin
            count_d    = limit;
            load_err_d = 1'b1;
          end else begin
            count_d = data;
          end
        end
        MODE_HOLD: begin
          count_d = count_q;
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
  end

  // Saturating wrap counter: stops at all-ones, never rolls over.
  always_comb begin
    wrap_d = wrap_q;
    if (wrap_evt && !(&wrap_q)) begin
      wrap_d = wrap_q + WRAP_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      load_err_q <= 1'b0;
      wrap_q     <= '0;
    end else begin
      count_q    <= count_d;
      load_err_q <= load_err_d;
      wrap_q     <= wrap_d;
    end
  end

  // Carry is high in the cycle preceding a wrap edge, so it can drive the
  // enable of the next cascaded stage directly.
  assign rco = enb && (((mode == MODE_UP) && at_top) ||
                       ((mode == MODE_DOWN) && at_bottom));

  assign Q        = count_q;
  assign load_err = load_err_q;
  assign wrap_cnt = wrap_q;

endmodule

// File: tb/tb_counter_mod_n.sv
// -----------------------------------------------------------------------------
// tb_counter_mod_n
//
// Self-checking bench for counter_mod_n. Two instances share all inputs: the
// default configuration (WIDTH=4, WRAP_W=8) and a narrow wrap counter
// (WRAP_W=2) to exercise saturation quickly. A reference model held as plain
// integers predicts count, error pulse, carry and both wrap counts.
// -----------------------------------------------------------------------------
module tb_counter_mod_n;

  logic       clk;
  logic       rst;
  logic       enb;
  logic [1:0] modo;
  logic [3:0] data;
  logic [3:0] limit;

  logic [3:0] q_big;
  logic       rco_big;
  logic       err_big;
  logic [7:0] wrap_big;

  logic [3:0] q_sml;
  logic       rco_sml;
  logic       err_sml;
  logic [1:0] wrap_sml;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_q;
  int m_err;
  int m_wrap;
  int m_wrap_sml;

  counter_mod_n #(.WIDTH(4), .WRAP_W(8)) u_big (
    .clk(clk), .rst(rst), .enb(enb), .modo(modo), .data(data), .limit(limit),
    .Q(q_big), .rco(rco_big), .load_err(err_big), .wrap_cnt(wrap_big)
  );

  counter_mod_n #(.WIDTH(4), .WRAP_W(2)) u_sml (
    .clk(clk), .rst(rst), .enb(enb), .modo(modo), .data(data), .limit(limit),
    .Q(q_sml), .rco(rco_sml), .load_err(err_sml), .wrap_cnt(wrap_sml)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q        = 0;
    m_err      = 0;
    m_wrap     = 0;
    m_wrap_sml = 0;
  endtask

  // One transaction: apply inputs just after an edge, check the carry in the
  // settled middle of the cycle, advance the model on the edge, then check
  // the registered outputs 1 time unit later.
  task automatic step(input bit e, input int m, input int d, input int l,
                      input bit verbose);
    bit exp_rco;
    bit wrapped;
    enb   = e;
    modo  = 2'(m);
    data  = 4'(d);
    limit = 4'(l);
    #3;
    exp_rco = e && ((m == 0 && m_q >= l) || (m == 1 && m_q == 0));
    check("rco", int'(rco_big), int'(exp_rco));
    check("rco_small", int'(rco_sml), int'(exp_rco));
    @(posedge clk);
    wrapped = 1'b0;
    m_err   = 0;
    if (e) begin
      case (m)
        0: if (m_q >= l) begin m_q = 0; wrapped = 1'b1; end
           else m_q = m_q + 1;
        1: if (m_q == 0) begin m_q = l; wrapped = 1'b1; end
           else m_q = m_q - 1;
        2: if (d > l) begin m_q = l; m_err = 1; end
           else m_q = d;
        default: ;
      endcase
    end
    if (wrapped) begin
      m_wrap     = (m_wrap + 1 > 255) ? 255 : m_wrap + 1;
      m_wrap_sml = (m_wrap_sml + 1 > 3) ? 3 : m_wrap_sml + 1;
    end
    #1;
    if (verbose)
      $display("txn enb=%0d modo=%0d data=%0d limit=%0d -> Q=%0d err=%0d wrap=%0d/%0d",
               e, m, d, l, q_big, err_big, wrap_big, wrap_sml);
    check("Q", int'(q_big), m_q);
    check("load_err", int'(err_big), m_err);
    check("wrap_cnt", int'(wrap_big), m_wrap);
    check("Q_small", int'(q_sml), m_q);
    check("load_err_small", int'(err_sml), m_err);
    check("wrap_cnt_small", int'(wrap_sml), m_wrap_sml);
  endtask

  // Synchronous-style reset pulse aligned to the transaction grid.
  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int lim;
    rst   = 1'b1;
    enb   = 1'b0;
    modo  = 2'b00;
    data  = 4'd0;
    limit = 4'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("reset_Q", int'(q_big), 0);
    check("reset_load_err", int'(err_big), 0);
    check("reset_wrap_cnt", int'(wrap_big), 0);

    // 1: full-range count up, one wrap
    for (int i = 0; i < 20; i++) step(1'b1, 0, 0, 15, 1'b1);
    check("t1_Q_literal", int'(q_big), 4);
    check("t1_wrap_literal", int'(wrap_big), 1);

    // 2: load 6 with limit 9, then count down through zero
    step(1'b1, 2, 6, 9, 1'b1);
    check("t2_load_literal", int'(q_big), 6);
    for (int i = 0; i < 8; i++) step(1'b1, 1, 0, 9, 1'b1);
    check("t2_Q_literal", int'(q_big), 8);
    check("t2_wrap_literal", int'(wrap_big), 2);

    // 3: clamped load, then a legal load clears the pulse
    step(1'b1, 2, 12, 9, 1'b1);
    check("t3_clamp_Q_literal", int'(q_big), 9);
    check("t3_clamp_err_literal", int'(err_big), 1);
    step(1'b1, 2, 3, 9, 1'b1);
    check("t3_load_Q_literal", int'(q_big), 3);
    check("t3_load_err_literal", int'(err_big), 0);

    // Back-to-back clamped loads keep the error high
    step(1'b1, 2, 14, 4, 1'b1);
    step(1'b1, 2, 13, 4, 1'b1);
    check("t3_b2b_err_literal", int'(err_big), 1);

    // 4: limit lowered below the count; next up edge wraps to 0
    step(1'b1, 2, 7, 9, 1'b1);
    step(1'b1, 0, 0, 5, 1'b1);
    check("t4_Q_literal", int'(q_big), 0);
    check("t4_wrap_literal", int'(wrap_big), 3);
    step(1'b1, 0, 0, 9, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 0, 11, 9, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 3, 11, 9, 1'b1);
    check("t4_frozen_Q_literal", int'(q_big), 1);
    check("t4_frozen_wrap_literal", int'(wrap_big), 3);

    // 5: narrow wrap counter saturates at 3
    pulse_reset();
    for (int i = 0; i < 12; i++) step(1'b1, 0, 0, 1, 1'b1);
    check("t5_wrap_small_literal", int'(wrap_sml), 3);
    check("t5_wrap_big_literal", int'(wrap_big), 6);

    // limit=0: counting stays at 0, every edge wraps; load clamps
    pulse_reset();
    step(1'b1, 0, 0, 0, 1'b1);
    step(1'b1, 1, 0, 0, 1'b1);
    check("lim0_Q_literal", int'(q_big), 0);
    check("lim0_wrap_literal", int'(wrap_big), 2);
    step(1'b1, 2, 5, 0, 1'b1);
    check("lim0_load_err_literal", int'(err_big), 1);

    // 6: asynchronous reset between edges with Q=5 and load_err high
    step(1'b1, 2, 12, 5, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_Q", int'(q_big), 0);
    check("t6_async_wrap", int'(wrap_big), 0);
    check("t6_async_err", int'(err_big), 0);
    #2;
    rst = 1'b0;
    model_reset();
    step(1'b0, 0, 0, 9, 1'b1);
    step(1'b1, 0, 0, 9, 1'b1);
    check("t6_resume_literal", int'(q_big), 1);

    // Randomised traffic with occasional extreme limits
    pulse_reset();
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 5))
        0:       lim = 0;
        1:       lim = 15;
        default: lim = $urandom_range(0, 15);
      endcase
      step(($urandom_range(0, 7) != 0), $urandom_range(0, 3),
           $urandom_range(0, 15), lim, 1'b0);
    end

    // Drive the 8-bit wrap counter into saturation
    for (int i = 0; i < 300; i++) step(1'b1, $urandom_range(0, 1), 0, 0, 1'b0);
    check("sat_wrap_big_literal", int'(wrap_big), 255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
